// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state encoding and counter sizing for the bit-serial adder.
package serial_adder_pkg;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_DONE    = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_t;

    // One extra bit so WIDTH-1 is representable without wrap for every legal WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction
endpackage

// File: rtl/full_adder_nand.sv
// full_adder_nand: 1-bit full adder built only from 2-input NAND gates.
module full_adder_nand (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);
    logic w_n1, w_n2, w_n3, w_x, w_n4, w_n5, w_n6;
    assign w_n1   = ~(i_a & i_b);
    assign w_n2   = ~(i_a & w_n1);
    assign w_n3   = ~(i_b & w_n1);
    assign w_x    = ~(w_n2 & w_n3);
    assign w_n4   = ~(w_x & i_cin);
    assign w_n5   = ~(w_x & w_n4);
    assign w_n6   = ~(i_cin & w_n4);
    assign o_sum  = ~(w_n5 & w_n6);
    assign o_cout = ~(w_n4 & w_n1);
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: sequences one NAND full adder over WIDTH cycles, LSB first,
// producing sum, carry-out and signed overflow behind a start/ready/done handshake.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             cin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int CW = cnt_width(WIDTH);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             w_s;
    logic             w_co;

    full_adder_nand u_fa (
        .i_a    (r_a[0]),
        .i_b    (r_b[0]),
        .i_cin  (r_carry),
        .o_sum  (w_s),
        .o_cout (w_co)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            ready    <= 1'b1;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    sum     <= {w_s, sum[WIDTH-1:1]};
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_co;
                    r_cnt   <= r_cnt + 1'b1;
                    // r_carry here is the carry into the MSB, w_co the carry out of it.
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_state  <= ST_DONE;
                        done     <= 1'b1;
                        cout     <= w_co;
                        overflow <= r_carry ^ w_co;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    done    <= 1'b0;
                    ready   <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    ready   <= 1'b1;
                    done    <= 1'b0;
                    if (start) begin
                        r_a     <= operand_a;
                        r_b     <= operand_b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                        ready   <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: drives WIDTH=8, 4 and 32 instances and checks them against a+b+cin arithmetic.
module tb_serial_adder_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        st;
    logic [63:0] a, b;
    logic        ci;
    int          sel;
    int          n_tests = 0;
    int          n_fail  = 0;

    logic        rdy8, dn8, co8, ov8;
    logic [7:0]  s8;
    logic        rdy4, dn4, co4, ov4;
    logic [3:0]  s4;
    logic        rdy32, dn32, co32, ov32;
    logic [31:0] s32;

    logic        o_ready, o_done, o_cout, o_ovf;
    logic [63:0] o_sum;
    logic        prev_done = 1'b0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clock(clk), .reset(rst), .start(st && sel == 0), .operand_a(a[7:0]), .operand_b(b[7:0]),
        .cin(ci), .ready(rdy8), .done(dn8), .sum(s8), .cout(co8), .overflow(ov8));
    serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clock(clk), .reset(rst), .start(st && sel == 1), .operand_a(a[3:0]), .operand_b(b[3:0]),
        .cin(ci), .ready(rdy4), .done(dn4), .sum(s4), .cout(co4), .overflow(ov4));
    serial_adder_ctrl #(.WIDTH(32)) dut32 (
        .clock(clk), .reset(rst), .start(st && sel == 2), .operand_a(a[31:0]), .operand_b(b[31:0]),
        .cin(ci), .ready(rdy32), .done(dn32), .sum(s32), .cout(co32), .overflow(ov32));

    always_comb begin
        o_ready = sel == 0 ? rdy8 : sel == 1 ? rdy4 : rdy32;
        o_done  = sel == 0 ? dn8  : sel == 1 ? dn4  : dn32;
        o_cout  = sel == 0 ? co8  : sel == 1 ? co4  : co32;
        o_ovf   = sel == 0 ? ov8  : sel == 1 ? ov4  : ov32;
        o_sum   = sel == 0 ? 64'(s8) : sel == 1 ? 64'(s4) : 64'(s32);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (width sel %0d, t=%0t)", tag, got, exp, sel, $time);
        end
    endtask

    function automatic int cur_w();
        return sel == 0 ? 8 : sel == 1 ? 4 : 32;
    endfunction

    // done must be a single-cycle pulse and never coincide with ready.
    always @(negedge clk) begin
        if (!rst && o_done) begin
            check("ready_with_done", 64'(o_ready), 64'd0);
            check("done_width", 64'(prev_done), 64'd0);
        end
        prev_done = o_done;
    end

    task automatic do_add(input logic [63:0] x, input logic [63:0] y, input logic c);
        int          w, n;
        logic [64:0] mask, full;
        logic [63:0] xm, ym, es;
        w    = cur_w();
        mask = (65'd1 << w) - 65'd1;
        xm   = x & mask[63:0];
        ym   = y & mask[63:0];
        full = {1'b0, xm} + {1'b0, ym} + 65'(c);
        es   = full[63:0] & mask[63:0];
        check("ready_before", 64'(o_ready), 64'd1);
        a = x; b = y; ci = c; st = 1'b1;
        @(negedge clk);
        st = 1'b0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; ci = 1'($urandom);
        n = 1;
        while (!o_done && n < w + 10) begin
            @(negedge clk);
            n++;
        end
        check("latency", 64'(n), 64'(w + 1));
        check("sum", o_sum, es);
        check("cout", 64'(o_cout), 64'(full[w]));
        check("overflow", 64'(o_ovf), 64'((xm[w-1] == ym[w-1]) && (es[w-1] != xm[w-1])));
        @(negedge clk);
        check("ready_after", 64'(o_ready), 64'd1);
        check("done_after", 64'(o_done), 64'd0);
    endtask

    initial begin
        int pulses, first, last;
        rst = 1'b1; st = 1'b0; a = '0; b = '0; ci = 1'b0; sel = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_ready", 64'(o_ready), 64'd1);
        check("rst_done", 64'(o_done), 64'd0);
        check("rst_sum", o_sum, 64'd0);
        check("rst_cout", 64'(o_cout), 64'd0);
        check("rst_ovf", 64'(o_ovf), 64'd0);

        do_add(64'h35, 64'h4A, 1'b0);
        do_add(64'hFF, 64'h01, 1'b0);
        do_add(64'h7F, 64'h01, 1'b0);
        do_add(64'h80, 64'h80, 1'b1);

        // Held start: accepted at cycle 0 and again at cycle 10 only.
        a = 64'h10; b = 64'h20; ci = 1'b0; st = 1'b1;
        pulses = 0; first = 0; last = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (o_done) begin
                pulses++;
                if (pulses == 1) first = i;
                last = i;
                check("busy_sum", o_sum, 64'h30);
            end
        end
        st = 1'b0;
        check("busy_pulses", 64'(pulses), 64'd2);
        check("busy_spacing", 64'(last - first), 64'd10);
        repeat (12) @(negedge clk);

        // Abort mid-RUN.
        a = 64'hAA; b = 64'h55; st = 1'b1;
        @(negedge clk);
        st = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", 64'(o_ready), 64'd1);
        check("abort_sum", o_sum, 64'd0);
        check("abort_cout", 64'(o_cout), 64'd0);
        check("abort_ovf", 64'(o_ovf), 64'd0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (o_done) pulses++;
            @(negedge clk);
        end
        check("abort_no_done", 64'(pulses), 64'd0);
        do_add(64'h01, 64'h01, 1'b0);

        sel = 1;
        for (int i = 0; i < 512; i++) do_add(64'(i & 15), 64'((i >> 4) & 15), 1'(i >> 8));

        sel = 2;
        for (int i = 0; i < 1000; i++) do_add(64'($urandom), 64'($urandom), 1'($urandom));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
